gsquare: RTL and testbench

- Stochastic-computing squarer, the inverse operation of the counter-feedback square-root unit.
- Input is a unipolar bitstream with P(in=1)=p; output is a bitstream with P(out=1)=p².
- The output is the AND of `in` with a decorrelated copy of itself. The copy comes from one of two sources, selected at run time:
  - regeneration: an up/down tracking counter compared against an external random number;
  - isolation: a flip-flop delay chain.
- Sits in the SC datapath between SNG/arithmetic units and downstream stream consumers.

---
 rtl/gsquare.sv | 64 ++++++
 tb/tb_gsquare.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gsquare.sv
// Stochastic squarer: out = in AND a decorrelated copy of in (counter regeneration or delay isolation).
// One-cycle registered latency; en=0 freezes counter, isolator and output.
module gsquare #(
  parameter int CWIDTH    = 4,
  parameter int ISO_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [CWIDTH-1:0] randNum,
  input  logic              in,
  output logic              out,
  output logic [CWIDTH-1:0] cnt_o
);

  localparam logic [CWIDTH-1:0] CNT_RST = {1'b1, {(CWIDTH-1){1'b0}}};
  localparam logic [CWIDTH-1:0] CNT_MAX = '1;

  logic [CWIDTH-1:0]    cnt_q, cnt_d;
  logic [ISO_DEPTH-1:0] iso_q, iso_d;
  logic                 out_q, out_d;
  logic                 regen;

  // P(regen) = cnt/2^CWIDTH, so the counter settles where regen tracks P(in).
  assign regen = (cnt_q > randNum);

  always_comb begin
    cnt_d = cnt_q;
    if (in && !regen && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!in && regen && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    iso_d    = iso_q;
    iso_d[0] = in;
    for (int k = 1; k < ISO_DEPTH; k++) begin
      iso_d[k] = iso_q[k-1];
    end
  end

  always_comb begin
    out_d = mode ? (in & iso_q[ISO_DEPTH-1]) : (in & regen);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_RST;
      iso_q <= '0;
      out_q <= 1'b0;
    end else if (en) begin
      cnt_q <= cnt_d;
      iso_q <= iso_d;
      out_q <= out_d;
    end
  end

  assign out   = out_q;
  assign cnt_o = cnt_q;

endmodule

// File: tb/tb_gsquare.sv
// Directed self-checking bench for gsquare: reset, counter saturation, isolator, enable hold, statistics.
module tb_gsquare;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          mode;
  logic          in_b;
  logic [CW-1:0] rnd;
  logic          out1, out3;
  logic [CW-1:0] cnt1, cnt3;

  int checks = 0;
  int errors = 0;

  logic [15:0] lfsr_a = 16'hACE1;
  logic [15:0] lfsr_b = 16'h1D2C;

  always #5 clk = ~clk;

  gsquare #(.CWIDTH(CW), .ISO_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .randNum(rnd),
    .in(in_b), .out(out1), .cnt_o(cnt1)
  );

  gsquare #(.CWIDTH(CW), .ISO_DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .randNum(rnd),
    .in(in_b), .out(out3), .cnt_o(cnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Advance each LFSR a full word so successive samples use fresh bits.
  task automatic lfsr_step();
    for (int i = 0; i < 16; i++) begin
      lfsr_a = lfsr_a[0] ? ((lfsr_a >> 1) ^ 16'hB400) : (lfsr_a >> 1);
      lfsr_b = lfsr_b[0] ? ((lfsr_b >> 1) ^ 16'hD008) : (lfsr_b >> 1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    en = 1'b1; mode = 1'b1; rnd = 4'd15; in_b = 1'b1;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cnt1 !== 4'd8) begin errors++; $display("FAIL reset_cnt: got %0d want 8", cnt1); end
    checks++;
    if (out1 !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", out1); end
    checks++;
    if (cnt3 !== 4'd8) begin errors++; $display("FAIL reset_cnt_d3: got %0d want 8", cnt3); end
    #2 rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (out1 !== (k >= 2)) begin
        errors++; $display("FAIL reset_first_out edge %0d: got %b want %b", k, out1, (k >= 2));
      end
    end
  endtask

  task automatic test_upper_sat();
    logic [CW-1:0] exp_cnt;
    do_reset();
    en = 1'b1; mode = 1'b0; rnd = 4'd15; in_b = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_cnt = (8 + k > 15) ? 4'd15 : 4'(8 + k);
      checks++;
      if (cnt1 !== exp_cnt) begin
        errors++; $display("FAIL upper_sat_cnt edge %0d: got %0d want %0d", k, cnt1, exp_cnt);
      end
      checks++;
      if (out1 !== 1'b0) begin
        errors++; $display("FAIL upper_sat_out edge %0d: got %b want 0", k, out1);
      end
    end
  endtask

  task automatic test_lower_sat();
    logic [CW-1:0] exp_cnt;
    do_reset();
    en = 1'b1; mode = 1'b0; rnd = 4'd0; in_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_cnt = (k >= 8) ? 4'd0 : 4'(8 - k);
      checks++;
      if (cnt1 !== exp_cnt) begin
        errors++; $display("FAIL lower_sat_cnt edge %0d: got %0d want %0d", k, cnt1, exp_cnt);
      end
      checks++;
      if (out1 !== 1'b0) begin
        errors++; $display("FAIL lower_sat_out edge %0d: got %b want 0", k, out1);
      end
    end
  endtask

  task automatic test_isolator();
    logic vin  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic vexp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    en = 1'b1; mode = 1'b1; rnd = 4'd7;
    for (int i = 0; i < 4; i++) begin
      in_b = vin[i];
      tick();
      checks++;
      if (out1 !== vexp[i]) begin
        errors++; $display("FAIL iso_pattern edge %0d: got %b want %b", i + 1, out1, vexp[i]);
      end
    end
    do_reset();
    in_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (out3 !== (k >= 4)) begin
        errors++; $display("FAIL iso_depth3 edge %0d: got %b want %b", k, out3, (k >= 4));
      end
    end
  endtask

  task automatic test_enable_hold();
    logic tog_in [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    en = 1'b1; mode = 1'b0; rnd = 4'd15; in_b = 1'b1;
    tick(); tick(); tick();
    mode = 1'b1;
    tick();
    checks++;
    if (cnt1 !== 4'd12 || out1 !== 1'b1) begin
      errors++; $display("FAIL hold_setup: got cnt=%0d out=%b want cnt=12 out=1", cnt1, out1);
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_b = tog_in[k];
      rnd  = 4'(k * 3);
      mode = k[0];
      tick();
      checks++;
      if (cnt1 !== 4'd12 || out1 !== 1'b1) begin
        errors++; $display("FAIL hold_frozen cycle %0d: got cnt=%0d out=%b want cnt=12 out=1", k, cnt1, out1);
      end
    end
    en = 1'b1; mode = 1'b1; rnd = 4'd15; in_b = 1'b1;
    tick();
    checks++;
    if (cnt1 !== 4'd13 || out1 !== 1'b1) begin
      errors++; $display("FAIL hold_resume_iso: got cnt=%0d out=%b want cnt=13 out=1", cnt1, out1);
    end
    mode = 1'b0; rnd = 4'd0; in_b = 1'b1;
    tick();
    checks++;
    if (cnt1 !== 4'd13 || out1 !== 1'b1) begin
      errors++; $display("FAIL hold_resume_regen: got cnt=%0d out=%b want cnt=13 out=1", cnt1, out1);
    end
  endtask

  task automatic run_stat(input logic m, input logic hi_p, input int target);
    int ones;
    ones = 0;
    do_reset();
    en = 1'b1; mode = m;
    for (int c = 0; c < 64 + 4096; c++) begin
      lfsr_step();
      in_b = hi_p ? (lfsr_a[0] | lfsr_a[1]) : lfsr_a[0];
      rnd  = lfsr_b[3:0];
      tick();
      if (c >= 64 && out1 === 1'b1) ones++;
    end
    checks++;
    if (ones < target - 96 || ones > target + 96) begin
      errors++; $display("FAIL stat mode=%b p=%s: got %0d ones want %0d+-96", m, hi_p ? "0.75" : "0.5", ones, target);
    end
  endtask

  task automatic test_statistics();
    run_stat(1'b0, 1'b0, 1024);
    run_stat(1'b1, 1'b0, 1024);
    run_stat(1'b0, 1'b1, 2304);
    run_stat(1'b1, 1'b1, 2304);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; in_b = 1'b0; rnd = '0;
    #12;
    test_reset();
    test_upper_sat();
    test_lower_sat();
    test_isolator();
    test_enable_hold();
    test_statistics();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
